scale_coord_gen: RTL

- Output-side coordinate generator for the scaler, directly downstream of the coefficient calculator.
- Consumes the per-axis reciprocal scale factors kX and kY and the enable inEn.
- For every output pixel, in raster order, produces the source-image integer coordinate and the 6-bit fractional interpolation weight.
- Feeds the line-buffer read and interpolation stage over a valid/ready handshake.

---
 rtl/scale_coord_gen_if.sv | 32 +++
 rtl/scale_coord_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scale_coord_gen_if.sv
// Coordinate stream from the scaler coordinate generator
// to the line-buffer read / interpolation stage.
interface scale_coord_gen_if #(
  parameter int IW = 11,
  parameter int OW = 11,
  parameter int FW = 6
);
  logic          oValid;
  logic          oReady;
  logic [IW-1:0] srcX;
  logic [IW-1:0] srcY;
  logic [FW-1:0] fracX;
  logic [FW-1:0] fracY;
  logic [OW-1:0] outX;
  logic [OW-1:0] outY;
  logic          lineEnd;
  logic          frameEnd;

  modport master (
    output oValid, srcX, srcY,
    output fracX, fracY, outX, outY,
    output lineEnd, frameEnd,
    input  oReady
  );

  modport slave (
    input  oValid, srcX, srcY,
    input  fracX, fracY, outX, outY,
    input  lineEnd, frameEnd,
    output oReady
  );
endinterface

// File: rtl/scale_coord_gen.sv
// Output-side coordinate generator: walks output pixels in raster
// order and emits clamped source coordinates plus 6-bit weights.
module scale_coord_gen #(
  parameter int INPUT_RES_WIDTH  = 11,
  parameter int OUTPUT_RES_WIDTH = 11,
  parameter int SCALE_BITS       = 8,
  parameter int FRAC_BITS        = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inEn,
  input  logic                        iVsyn,
  input  logic [SCALE_BITS-1:0]       kX,
  input  logic [SCALE_BITS-1:0]       kY,
  input  logic [INPUT_RES_WIDTH-1:0]  xBgn,
  input  logic [INPUT_RES_WIDTH-1:0]  xEnd,
  input  logic [INPUT_RES_WIDTH-1:0]  yBgn,
  input  logic [INPUT_RES_WIDTH-1:0]  yEnd,
  input  logic [OUTPUT_RES_WIDTH-1:0] outXRes,
  input  logic [OUTPUT_RES_WIDTH-1:0] outYRes,
  scale_coord_gen_if.master           co
);

  localparam int IW = INPUT_RES_WIDTH;
  localparam int OW = OUTPUT_RES_WIDTH;
  localparam int AW = IW + FRAC_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE
  } state_e;

  state_e          state_q, state_d;
  logic            vs_q;
  logic            vs_rise;
  logic            valid_q, valid_d;
  logic [AW-1:0]   accX_q, accX_d;
  logic [AW-1:0]   accY_q, accY_d;
  logic [SCALE_BITS-1:0] kXr_q, kXr_d;
  logic [SCALE_BITS-1:0] kYr_q, kYr_d;
  logic [OW-1:0]   outX_q, outX_d;
  logic [OW-1:0]   outY_q, outY_d;

  logic            xfer;
  logic            x_more;
  logic            y_more;
  logic [AW-1:0]   xbase;
  logic [AW-1:0]   ybase;
  logic [AW-1:0]   kx_ext;
  logic [AW-1:0]   ky_ext;

  assign vs_rise = iVsyn & ~vs_q;
  assign xfer    = valid_q & co.oReady;
  assign x_more  = outX_q < outXRes;
  assign y_more  = outY_q < outYRes;
  assign xbase   = {1'b0, xBgn, {FRAC_BITS{1'b0}}};
  assign ybase   = {1'b0, yBgn, {FRAC_BITS{1'b0}}};
  assign kx_ext  = {{(AW-SCALE_BITS){1'b0}}, kXr_q};
  assign ky_ext  = {{(AW-SCALE_BITS){1'b0}}, kYr_q};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    accX_d  = accX_q;
    accY_d  = accY_q;
    kXr_d   = kXr_q;
    kYr_d   = kYr_q;
    outX_d  = outX_q;
    outY_d  = outY_q;
    unique case (state_q)
      IDLE: begin
        if (inEn) state_d = WAIT_FRAME;
      end
      WAIT_FRAME, ACTIVE: begin
        // Resync wins over a transfer in the same cycle.
        if (vs_rise) begin
          state_d = ACTIVE;
          valid_d = 1'b1;
          kXr_d   = kX;
          kYr_d   = kY;
          accX_d  = xbase;
          accY_d  = ybase;
          outX_d  = '0;
          outY_d  = '0;
        end else if (xfer) begin
          if (x_more) begin
            outX_d = outX_q + 1'b1;
            accX_d = accX_q + kx_ext;
          end else begin
            outX_d = '0;
            accX_d = xbase;
            if (y_more) begin
              outY_d = outY_q + 1'b1;
              accY_d = accY_q + ky_ext;
            end else begin
              state_d = WAIT_FRAME;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!inEn) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      valid_q <= 1'b0;
      accX_q  <= '0;
      accY_q  <= '0;
      kXr_q   <= '0;
      kYr_q   <= '0;
      outX_q  <= '0;
      outY_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= iVsyn;
      valid_q <= valid_d;
      accX_q  <= accX_d;
      accY_q  <= accY_d;
      kXr_q   <= kXr_d;
      kYr_q   <= kYr_d;
      outX_q  <= outX_d;
      outY_q  <= outY_d;
    end
  end

  logic [IW-1:0] rawX, rawY;
  logic          clX, clY;

  // Top accumulator bit flags overshoot past the addressable range.
  assign rawX = accX_q[AW-2:FRAC_BITS];
  assign rawY = accY_q[AW-2:FRAC_BITS];
  assign clX  = accX_q[AW-1] | (rawX > xEnd);
  assign clY  = accY_q[AW-1] | (rawY > yEnd);

  assign co.srcX     = clX ? xEnd : rawX;
  assign co.srcY     = clY ? yEnd : rawY;
  assign co.fracX    = clX ? '0 : accX_q[FRAC_BITS-1:0];
  assign co.fracY    = clY ? '0 : accY_q[FRAC_BITS-1:0];
  assign co.oValid   = valid_q;
  assign co.outX     = outX_q;
  assign co.outY     = outY_q;
  assign co.lineEnd  = valid_q & (outX_q == outXRes);
  assign co.frameEnd = co.lineEnd & (outY_q == outYRes);

endmodule
